// File: rtl/modmul_pkg.sv
// Shared helpers for the modular multiplier stream front-end: credit-counter sizing,
// parameter legality checks and the multiplier pipeline latency.
package modmul_pkg;

    // Holds 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit lat_ok(input int unsigned lat);
        return lat >= 1;
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return depth >= 1;
    endfunction

    // Operand register + multiplier stages + reduction stages + result register.
    function automatic int unsigned modmul_lat(input int unsigned mul_stages,
                                               input int unsigned red_stages);
        return mul_stages + red_stages + 2;
    endfunction

endpackage

// File: rtl/modmul_res_fifo.sv
// First-word-fall-through synchronous FIFO holding multiplier results.
module modmul_res_fifo
    import modmul_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop = pop && !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= next_ptr(wr_ptr);
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/modmul_stream_ctrl.sv
// Valid/ready front-end for the fixed-latency, non-stallable modular multiplier.
// Optional tag pass-through enabled by defining MODMUL_STREAM_TAG_EN.
module modmul_stream_ctrl
    import modmul_pkg::*;
#(
    parameter int unsigned LOGQ       = 32,
    parameter int unsigned LOGT       = 32,
    parameter int unsigned LAT        = 6,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TAGW       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] in_A,
    input  logic [LOGQ-1:0] in_B,
    output logic [LOGQ-1:0] mm_A,
    output logic [LOGQ-1:0] mm_B,
    input  logic [LOGT-1:0] mm_T,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGT-1:0] out_T,
    output logic            idle
`ifdef MODMUL_STREAM_TAG_EN
    ,
    input  logic [TAGW-1:0] in_tag,
    output logic [TAGW-1:0] out_tag
`endif
);
    if (!lat_ok(LAT)) begin : g_bad_lat
        $error("modmul_stream_ctrl: LAT must be >= 1");
    end
    if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
        $error("modmul_stream_ctrl: FIFO_DEPTH must be >= 1");
    end
    if (TAGW < 1) begin : g_bad_tagw
        $error("modmul_stream_ctrl: TAGW must be >= 1");
    end

    localparam int unsigned CW = cnt_width(FIFO_DEPTH);
`ifdef MODMUL_STREAM_TAG_EN
    localparam int unsigned FW = LOGT + TAGW;
`else
    localparam int unsigned FW = LOGT;
`endif

    logic [CW-1:0]  cnt;
    logic [LAT-1:0] vld_sr;
    logic           fire;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FW-1:0]  push_data;
    logic [FW-1:0]  head;

    assign mm_A = in_A;
    assign mm_B = in_B;

    // Credits cover in-flight issues plus FIFO occupancy, so a capture always has room.
    assign in_ready  = !rst && (cnt < CW'(FIFO_DEPTH));
    assign fire      = in_valid && in_ready;
    assign out_valid = !rst && !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign idle      = !rst && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            cnt    <= '0;
        end else begin
            vld_sr[0] <= fire;
            for (int unsigned i = 1; i < LAT; i++) vld_sr[i] <= vld_sr[i-1];
            cnt <= cnt + CW'(fire) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(vld_sr[LAT-1] && fifo_full));
    end

`ifdef MODMUL_STREAM_TAG_EN
    // Each stage loads only when a valid issue moves into it, so tags stay aligned with vld_sr.
    logic [TAGW-1:0] tag_sr [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LAT; i++) tag_sr[i] <= '0;
        end else begin
            if (fire) tag_sr[0] <= in_tag;
            for (int unsigned i = 1; i < LAT; i++) begin
                if (vld_sr[i-1]) tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    assign push_data        = {tag_sr[LAT-1], mm_T};
    assign {out_tag, out_T} = head;
`else
    assign push_data = mm_T;
    assign out_T     = head;
`endif

    modmul_res_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_sr[LAT-1]),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_modmul_stream_ctrl.sv
// Self-checking bench for modmul_stream_ctrl with a 6-cycle A*B mod q multiplier model.
module tb_modmul_stream_ctrl;
    localparam int unsigned LOGQ  = 32;
    localparam int unsigned LOGT  = 32;
    localparam int unsigned LAT   = 6;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TAGW  = 4;
    localparam logic [63:0] Q     = 64'd4294967291;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] in_A;
    logic [LOGQ-1:0] in_B;
    logic [LOGQ-1:0] mm_A;
    logic [LOGQ-1:0] mm_B;
    logic [LOGT-1:0] mm_T;
    logic            out_valid;
    logic            out_ready;
    logic [LOGT-1:0] out_T;
    logic            idle;
`ifdef MODMUL_STREAM_TAG_EN
    logic [TAGW-1:0] in_tag;
    logic [TAGW-1:0] out_tag;
    logic [TAGW-1:0] tag_q [$];
`endif

    modmul_stream_ctrl #(
        .LOGQ       (LOGQ),
        .LOGT       (LOGT),
        .LAT        (LAT),
        .FIFO_DEPTH (DEPTH),
        .TAGW       (TAGW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .mm_A      (mm_A),
        .mm_B      (mm_B),
        .mm_T      (mm_T),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_T     (out_T),
        .idle      (idle)
`ifdef MODMUL_STREAM_TAG_EN
        ,
        .in_tag    (in_tag),
        .out_tag   (out_tag)
`endif
    );

    function automatic logic [LOGT-1:0] model(input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b);
        return LOGT'((64'(a) * 64'(b)) % Q);
    endfunction

    // Multiplier model: result of the operand cycle visible LAT cycles later.
    logic [LOGT-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= model(mm_A, mm_B);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mm_T = pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fires, n_pops, first_pop_cyc, last_pop_cyc, n_ready_low;
    logic [LOGT-1:0] exp_q [$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Sample away from the edge; push on fire, pop and compare on output handshake.
    task automatic sample();
        #2;
        if (in_valid && in_ready) begin
            exp_q.push_back(model(in_A, in_B));
`ifdef MODMUL_STREAM_TAG_EN
            tag_q.push_back(in_tag);
`endif
            n_fires++;
        end
        if (out_valid && out_ready) begin
            if (n_pops == 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            n_pops++;
            if (exp_q.size() == 0) fail_now("spurious_output");
            else check("out_T", out_T, exp_q.pop_front());
`ifdef MODMUL_STREAM_TAG_EN
            if (tag_q.size() != 0) check("out_tag", out_tag, tag_q.pop_front());
`endif
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
            sample();
            tick();
        end
        check("drained", exp_q.size(), 0);
    endtask

    task automatic issue_one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int fire_cyc;
        bit seen;
        in_valid  = 1'b1;
        in_A      = a;
        in_B      = b;
        out_ready = 1'b1;
        sample();
        check("single_in_ready", in_ready, 1);
        fire_cyc = cyc;
        tick();
        in_valid = 1'b0;
        in_A     = '0;
        in_B     = '0;
        seen     = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            sample();
            if (out_valid) begin
                seen = 1'b1;
                check("single_latency", cyc - fire_cyc, LAT + 1);
                check("single_out_T", out_T, exp);
            end
            tick();
        end
        if (!seen) fail_now("single_timeout");
        sample();
        check("single_idle_after_pop", idle, 1);
        check("single_out_valid_after_pop", out_valid, 0);
        tick();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{32'd3, 32'd5, 32'd15};
        vecs[1] = '{32'd0, 32'd12345, 32'd0};
        vecs[2] = '{32'd1, 32'd4294967290, 32'd4294967290};
        vecs[3] = '{32'd4294967290, 32'd4294967290, 32'd1};
        vecs[4] = '{32'd65536, 32'd65536, 32'd5};
        vecs[5] = '{32'd4294967290, 32'd2, 32'd4294967289};
        vecs[6] = '{32'd123456, 32'd1000, 32'd123456000};

        n_fires = 0; n_pops = 0; first_pop_cyc = 0; last_pop_cyc = 0; n_ready_low = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_A      = 32'd7;
        in_B      = 32'd9;
`ifdef MODMUL_STREAM_TAG_EN
        in_tag    = '0;
`endif

        // Reset held 3 cycles with in_valid high.
        for (int i = 0; i < 3; i++) begin
            sample();
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_idle", idle, 0);
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        sample();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_idle", idle, 1);
        check("post_rst_out_valid", out_valid, 0);
        tick();

        for (int v = 0; v < 7; v++) issue_one(vecs[v].a, vecs[v].b, vecs[v].exp);

        // Streaming: 100 back-to-back issues with the consumer always ready.
        begin
            int t0;
            t0 = 0;
            n_fires = 0; n_pops = 0; n_ready_low = 0;
            out_ready = 1'b1;
            for (int i = 0; i < 100; i++) begin
                in_valid = 1'b1;
                in_A     = $urandom();
                in_B     = $urandom();
                sample();
                if (i == 0) t0 = cyc;
                if (!in_ready) n_ready_low++;
                tick();
            end
            drain();
            check("stream_ready_drops", n_ready_low, 0);
            check("stream_fires", n_fires, 100);
            check("stream_outputs", n_pops, 100);
            check("stream_first_out", first_pop_cyc - t0, LAT + 1);
            check("stream_last_out", last_pop_cyc - t0, 106);
        end

        // Backpressure: credits stop issue at DEPTH, then one issue per pop.
        n_fires = 0; n_pops = 0; n_ready_low = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_A     = $urandom_range(1, 100000);
            in_B     = $urandom_range(1, 100000);
            sample();
            tick();
        end
        check("bp_fires", n_fires, DEPTH);
        sample();
        check("bp_full_in_ready", in_ready, 0);
        check("bp_full_out_valid", out_valid, 1);
        check("bp_full_idle", idle, 0);
        tick();
        out_ready = 1'b1;
        sample();
        check("bp_ready_during_pop", in_ready, 0);
        tick();
        sample();
        check("bp_ready_after_pop", in_ready, 1);
        tick();
        for (int i = 0; i < 30; i++) begin
            in_A = $urandom();
            in_B = $urandom();
            sample();
            if (!in_ready || !out_valid) n_ready_low++;
            tick();
        end
        check("bp_steady_one_per_pop", n_ready_low, 0);
        drain();
        check("bp_no_loss", n_pops, n_fires);

        // Reset mid-flight discards in-flight issues.
        n_fires = 0; n_pops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_A     = $urandom_range(1, 1000);
            in_B     = $urandom_range(1, 1000);
            sample();
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            tick();
        end
        rst = 1'b1;
        sample();
        check("midrst_in_ready", in_ready, 0);
        check("midrst_idle", idle, 0);
        tick();
        rst = 1'b0;
        exp_q.delete();
`ifdef MODMUL_STREAM_TAG_EN
        tag_q.delete();
`endif
        sample();
        check("midrst_idle_after", idle, 1);
        tick();
        for (int i = 0; i < 15; i++) begin
            sample();
            tick();
        end
        check("midrst_no_outputs", n_pops, 0);
        issue_one(32'd3, 32'd5, 32'd15);

`ifdef MODMUL_STREAM_TAG_EN
        // Tags 0..15 with random consumer stalls.
        n_pops = 0;
        for (int t = 0; t < 16; t++) begin
            bit done;
            done = 1'b0;
            for (int k = 0; k < 50 && !done; k++) begin
                in_valid  = 1'b1;
                in_tag    = TAGW'(t);
                in_A      = $urandom();
                in_B      = $urandom();
                out_ready = 1'($urandom_range(0, 1));
                sample();
                done = in_ready;
                tick();
            end
            if (!done) fail_now("tag_issue_timeout");
        end
        drain();
        check("tag_outputs", n_pops, 16);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
